// File: rtl/m4_result_writer_if.sv
// Result stream in and M4 write port out, as one bundle.
// slave: the writer. master: the upstream producer and the M4 observer.
interface m4_result_writer_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              M4_WriteEnable;
    logic [ADDR_W-1:0] M4_WriteAddress;
    logic [DATA_W-1:0] M4_WriteBus;

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output M4_WriteEnable, M4_WriteAddress, M4_WriteBus
    );

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  M4_WriteEnable, M4_WriteAddress, M4_WriteBus
    );
endinterface

// File: rtl/m4_result_writer.sv
// Result sink: buffers words in a FIFO and drains them into M4.
// Ports: clock, reset_n, start, word_count, busy, done, bus (stream + M4).
module m4_result_writer #(
    parameter int                 DATA_W     = 128,
    parameter int                 ADDR_W     = 16,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   word_count,
    output logic                busy,
    output logic                done,
    m4_result_writer_if.slave   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   target_q;
    logic [ADDR_W-1:0]   acc_cnt_q;
    logic [ADDR_W-1:0]   wr_cnt_q;
    logic [PW-1:0]       wptr_q;
    logic [PW-1:0]       rptr_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                busy_q;
    logic                done_q;

    logic fifo_empty;
    logic fifo_full;
    logic in_ready_d;
    logic push;
    logic pop;

    // Extra pointer bit separates full from empty when indices match.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign in_ready_d = (state_q == S_RUN) && !fifo_full &&
                        (acc_cnt_q < target_q);
    assign push = bus.in_valid && in_ready_d;
    assign pop  = (state_q == S_RUN) && !fifo_empty;

    assign bus.in_ready        = in_ready_d;
    assign bus.M4_WriteEnable  = we_q;
    assign bus.M4_WriteAddress = addr_q;
    assign bus.M4_WriteBus     = data_q;
    assign busy                = busy_q;
    assign done                = done_q;

    // Storage only; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;

            if (push) begin
                wptr_q    <= wptr_q + PW'(1);
                acc_cnt_q <= acc_cnt_q + ADDR_W'(1);
            end

            if (pop) begin
                rptr_q   <= rptr_q + PW'(1);
                wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
                we_q     <= 1'b1;
                addr_q   <= BASE_ADDR + wr_cnt_q;
                data_q   <= mem_q[rptr_q[AW-1:0]];
            end

            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target_q  <= word_count;
                        acc_cnt_q <= '0;
                        wr_cnt_q  <= '0;
                        wptr_q    <= '0;
                        rptr_q    <= '0;
                        if (word_count != '0) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Reached only after the last strobe has been issued.
                    if (wr_cnt_q == target_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m4_result_writer.sv
// Directed bench for m4_result_writer.
// Two instances: BASE_ADDR 0 (main) and 16'hFFFE (address wrap).
module tb_m4_result_writer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] wc;
    logic        busy;
    logic        done;
    logic        start2;
    logic [15:0] wc2;
    logic        busy2;
    logic        done2;

    int n_cmp;
    int n_err;
    int sent;
    int got;
    logic xfer;

    m4_result_writer_if #(.DATA_W(128), .ADDR_W(16)) u_if ();
    m4_result_writer_if #(.DATA_W(128), .ADDR_W(16)) w_if ();

    m4_result_writer #(
        .DATA_W(128), .ADDR_W(16), .FIFO_DEPTH(4), .BASE_ADDR(16'h0000)
    ) dut (
        .clock(clk), .reset_n(reset_n), .start(start),
        .word_count(wc), .busy(busy), .done(done), .bus(u_if.slave)
    );

    m4_result_writer #(
        .DATA_W(128), .ADDR_W(16), .FIFO_DEPTH(4), .BASE_ADDR(16'hFFFE)
    ) dut_w (
        .clock(clk), .reset_n(reset_n), .start(start2),
        .word_count(wc2), .busy(busy2), .done(done2), .bus(w_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {w, ~w, w, 32'(i)};
    endfunction

    task automatic c1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic c16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic c128(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_chk(input string tag, input logic [15:0] a,
                          input logic [127:0] d);
        c1({tag, "_we"}, u_if.M4_WriteEnable, 1'b1);
        c16({tag, "_addr"}, u_if.M4_WriteAddress, a);
        c128({tag, "_bus"}, u_if.M4_WriteBus, d);
    endtask

    logic [15:0] wrap_a [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        start = 1'b0;
        wc = '0;
        start2 = 1'b0;
        wc2 = '0;
        u_if.in_valid = 1'b0;
        u_if.in_data = '0;
        w_if.in_valid = 1'b0;
        w_if.in_data = '0;
        wrap_a[0] = 16'hFFFE;
        wrap_a[1] = 16'hFFFF;
        wrap_a[2] = 16'h0000;
        wrap_a[3] = 16'h0001;

        // reset state
        @(negedge clk);
        @(negedge clk);
        c1("rst_rdy", u_if.in_ready, 1'b0);
        c1("rst_we", u_if.M4_WriteEnable, 1'b0);
        c16("rst_addr", u_if.M4_WriteAddress, 16'h0);
        c128("rst_bus", u_if.M4_WriteBus, 128'h0);
        c1("rst_busy", busy, 1'b0);
        c1("rst_done", done, 1'b0);
        reset_n = 1'b1;

        // zero-length job from IDLE
        @(negedge clk);
        start = 1'b1;
        wc = 16'd0;
        u_if.in_valid = 1'b1;
        u_if.in_data = mk(99);
        c1("z_rdy0", u_if.in_ready, 1'b0);
        @(negedge clk);
        start = 1'b0;
        c1("z_done", done, 1'b1);
        c1("z_busy", busy, 1'b0);
        c1("z_rdy1", u_if.in_ready, 1'b0);
        c1("z_we1", u_if.M4_WriteEnable, 1'b0);
        @(negedge clk);
        c1("z_we2", u_if.M4_WriteEnable, 1'b0);
        c1("z_rdy2", u_if.in_ready, 1'b0);
        u_if.in_valid = 1'b0;

        // basic job, 3 words, relaunched from DONE
        start = 1'b1;
        wc = 16'd3;
        @(negedge clk);
        start = 1'b0;
        c1("b_busy", busy, 1'b1);
        c1("b_done", done, 1'b0);
        c1("b_rdy", u_if.in_ready, 1'b1);
        u_if.in_valid = 1'b1;
        u_if.in_data = 128'h1;
        @(negedge clk);
        c1("b_we0", u_if.M4_WriteEnable, 1'b0);
        u_if.in_data = 128'h2;
        @(negedge clk);
        wr_chk("b_w0", 16'h0, 128'h1);
        u_if.in_data = 128'h3;
        @(negedge clk);
        wr_chk("b_w1", 16'h1, 128'h2);
        c1("b_rdy_end", u_if.in_ready, 1'b0);
        u_if.in_valid = 1'b0;
        @(negedge clk);
        wr_chk("b_w2", 16'h2, 128'h3);
        c1("b_done_early", done, 1'b0);
        @(negedge clk);
        c1("b_we_off", u_if.M4_WriteEnable, 1'b0);
        c1("b_done_fin", done, 1'b1);
        c1("b_busy_fin", busy, 1'b0);
        c16("b_addr_hold", u_if.M4_WriteAddress, 16'h2);

        // 8 words, in_valid held high
        start = 1'b1;
        wc = 16'd8;
        @(negedge clk);
        start = 1'b0;
        u_if.in_valid = 1'b1;
        u_if.in_data = mk(0);
        sent = 0;
        got = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            xfer = u_if.in_ready && u_if.in_valid;
            @(negedge clk);
            if (u_if.M4_WriteEnable) begin
                c16("bp_addr", u_if.M4_WriteAddress, 16'(got));
                c128("bp_bus", u_if.M4_WriteBus, mk(got));
                got++;
            end
            if (xfer) begin
                sent++;
                u_if.in_data = mk(sent);
            end
            c1("bp_occ", (sent - got) <= 4, 1'b1);
            if (!u_if.in_ready && sent < 8)
                c16("bp_full", 16'(sent - got), 16'd4);
            if (sent == 8)
                u_if.in_valid = 1'b0;
        end
        u_if.in_valid = 1'b0;
        c16("bp_sent", 16'(sent), 16'd8);
        c16("bp_got", 16'(got), 16'd8);
        c1("bp_done", done, 1'b1);

        // bubbly input, then an excess word
        start = 1'b1;
        wc = 16'd4;
        @(negedge clk);
        start = 1'b0;
        c1("bb_busy", busy, 1'b1);
        u_if.in_valid = 1'b1;
        u_if.in_data = mk(48);
        @(negedge clk);
        c1("bb_we_t0", u_if.M4_WriteEnable, 1'b0);
        u_if.in_data = mk(49);
        @(negedge clk);
        wr_chk("bb_w0", 16'h0, mk(48));
        u_if.in_valid = 1'b0;
        @(negedge clk);
        wr_chk("bb_w1", 16'h1, mk(49));
        @(negedge clk);
        c1("bb_gap1", u_if.M4_WriteEnable, 1'b0);
        u_if.in_valid = 1'b1;
        u_if.in_data = mk(50);
        c1("bb_rdy2", u_if.in_ready, 1'b1);
        @(negedge clk);
        c1("bb_we_t2", u_if.M4_WriteEnable, 1'b0);
        u_if.in_valid = 1'b0;
        @(negedge clk);
        wr_chk("bb_w2", 16'h2, mk(50));
        @(negedge clk);
        c1("bb_gap2a", u_if.M4_WriteEnable, 1'b0);
        @(negedge clk);
        c1("bb_gap2b", u_if.M4_WriteEnable, 1'b0);
        u_if.in_valid = 1'b1;
        u_if.in_data = mk(51);
        @(negedge clk);
        c1("bb_we_t3", u_if.M4_WriteEnable, 1'b0);
        c1("bb_rdy_x0", u_if.in_ready, 1'b0);
        u_if.in_data = mk(52);
        @(negedge clk);
        wr_chk("bb_w3", 16'h3, mk(51));
        c1("bb_rdy_x1", u_if.in_ready, 1'b0);
        @(negedge clk);
        c1("bb_we_x", u_if.M4_WriteEnable, 1'b0);
        c1("bb_done", done, 1'b1);
        c16("bb_addr", u_if.M4_WriteAddress, 16'h3);
        u_if.in_valid = 1'b0;

        // address wrap on the BASE_ADDR=FFFE instance
        start2 = 1'b1;
        wc2 = 16'd4;
        @(negedge clk);
        start2 = 1'b0;
        c1("wr_busy", busy2, 1'b1);
        w_if.in_valid = 1'b1;
        w_if.in_data = mk(16);
        for (int j = 0; j < 5; j++) begin
            if (j < 4)
                c1("wr_rdy", w_if.in_ready, 1'b1);
            @(negedge clk);
            if (j < 3)
                w_if.in_data = mk(16 + j + 1);
            else
                w_if.in_valid = 1'b0;
            if (j >= 1) begin
                c1("wr_we", w_if.M4_WriteEnable, 1'b1);
                c16("wr_addr", w_if.M4_WriteAddress, wrap_a[j-1]);
                c128("wr_bus", w_if.M4_WriteBus, mk(16 + j - 1));
            end
        end
        @(negedge clk);
        c1("wr_done", done2, 1'b1);
        c1("wr_we_off", w_if.M4_WriteEnable, 1'b0);

        // reset mid-job, then restart
        start = 1'b1;
        wc = 16'd6;
        @(negedge clk);
        start = 1'b0;
        u_if.in_valid = 1'b1;
        u_if.in_data = mk(64);
        @(negedge clk);
        u_if.in_data = mk(65);
        @(negedge clk);
        wr_chk("rr_w0", 16'h0, mk(64));
        u_if.in_data = mk(66);
        @(negedge clk);
        wr_chk("rr_w1", 16'h1, mk(65));
        reset_n = 1'b0;
        #1;
        c1("rr_we", u_if.M4_WriteEnable, 1'b0);
        c16("rr_addr", u_if.M4_WriteAddress, 16'h0);
        c128("rr_bus", u_if.M4_WriteBus, 128'h0);
        c1("rr_busy", busy, 1'b0);
        c1("rr_done", done, 1'b0);
        c1("rr_rdy", u_if.in_ready, 1'b0);
        @(negedge clk);
        c1("rr_we_hold", u_if.M4_WriteEnable, 1'b0);
        reset_n = 1'b1;
        u_if.in_valid = 1'b0;
        @(negedge clk);
        c1("rr_we_rel", u_if.M4_WriteEnable, 1'b0);
        c1("rr_busy_rel", busy, 1'b0);
        start = 1'b1;
        wc = 16'd2;
        @(negedge clk);
        start = 1'b0;
        c1("rs_busy", busy, 1'b1);
        u_if.in_valid = 1'b1;
        u_if.in_data = mk(32);
        @(negedge clk);
        c1("rs_we_t0", u_if.M4_WriteEnable, 1'b0);
        u_if.in_data = mk(33);
        @(negedge clk);
        wr_chk("rs_w0", 16'h0, mk(32));
        u_if.in_valid = 1'b0;
        @(negedge clk);
        wr_chk("rs_w1", 16'h1, mk(33));
        @(negedge clk);
        c1("rs_done", done, 1'b1);
        c1("rs_we_off", u_if.M4_WriteEnable, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
